// File: rtl/elev_pkg.sv
// Shared definitions for the elevator call scheduler: state encoding and default sizing.
package elev_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DOOR = 2'd3
    } state_t;

    localparam int N_FLOORS_DEF    = 8;
    localparam int FLOOR_W_DEF     = 3;
    localparam int MOVE_CYCLES_DEF = 8;
    localparam int DOOR_CYCLES_DEF = 16;

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter that stops at zero; shared by the move and door intervals.
module elev_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         done
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (en && value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign done = (value == '0);

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN elevator scheduler: latches calls, steps the floor counter, times the door.
// Optional EMERGENCY_STOP_EN adds estop_n, which freezes motion and timers while low.
module elevator_call_scheduler
    import elev_pkg::*;
#(
    parameter int N_FLOORS    = N_FLOORS_DEF,
    parameter int FLOOR_W     = FLOOR_W_DEF,
    parameter int MOVE_CYCLES = MOVE_CYCLES_DEF,
    parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
`ifdef EMERGENCY_STOP_EN
    input  logic                estop_n,
`endif
    input  logic [N_FLOORS-1:0] call_n,
    output logic                up_n,
    output logic                down_n,
    output logic                hold,
    output logic [FLOOR_W-1:0]  floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                door_open,
    output logic                dir_up,
    output logic                top_alarm
);

    localparam int TMAX    = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W = $clog2(TMAX);
    localparam logic [TIMER_W-1:0] MOVE_LOAD = TIMER_W'(MOVE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP       = FLOOR_W'(N_FLOORS - 1);

    state_t               state, state_d;
    logic [FLOOR_W-1:0]   floor_d, floor_up, floor_dn;
    logic [N_FLOORS-1:0]  pending_d;
    logic                 dir_up_d;
    logic                 step, step_d;
    logic                 ahead_up, ahead_dn;
    logic                 run;
    logic                 t_load, t_done;
    logic [TIMER_W-1:0]   t_value, t_count;

`ifdef EMERGENCY_STOP_EN
    assign run = estop_n;
`else
    assign run = 1'b1;
`endif

    elev_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (t_load),
        .en         (run),
        .load_value (t_value),
        .value      (t_count),
        .done       (t_done)
    );

    assign floor_up = (floor == TOP)   ? floor : floor + 1'b1;
    assign floor_dn = (floor == '0)    ? floor : floor - 1'b1;

    always_comb begin
        ahead_up = 1'b0;
        ahead_dn = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(floor)) ahead_up = ahead_up | pending[i];
            if (i < int'(floor)) ahead_dn = ahead_dn | pending[i];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state;
        floor_d   = floor;
        dir_up_d  = dir_up;
        step_d    = 1'b0;
        pending_d = pending | ~call_n;
        t_load    = 1'b0;
        t_value   = MOVE_LOAD;
        if (run) begin
            unique case (state)
                IDLE: begin
                    if (pending[floor]) begin
                        state_d            = DOOR;
                        pending_d[floor]   = 1'b0;
                        t_load             = 1'b1;
                        t_value            = DOOR_LOAD;
                    end else if (ahead_up && (dir_up || !ahead_dn)) begin
                        state_d  = UP;
                        dir_up_d = 1'b1;
                        step_d   = 1'b1;
                        t_load   = 1'b1;
                    end else if (ahead_dn) begin
                        state_d  = DOWN;
                        dir_up_d = 1'b0;
                        step_d   = 1'b1;
                        t_load   = 1'b1;
                    end
                end
                UP: begin
                    if (t_done) begin
                        floor_d = floor_up;
                        if (pending[floor_up]) begin
                            state_d             = DOOR;
                            pending_d[floor_up] = 1'b0;
                            t_load              = 1'b1;
                            t_value             = DOOR_LOAD;
                        end else if (ahead_up && floor_up != TOP) begin
                            step_d = 1'b1;
                            t_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DOWN: begin
                    if (t_done) begin
                        floor_d = floor_dn;
                        if (pending[floor_dn]) begin
                            state_d             = DOOR;
                            pending_d[floor_dn] = 1'b0;
                            t_load              = 1'b1;
                            t_value             = DOOR_LOAD;
                        end else if (ahead_dn && floor_dn != '0) begin
                            step_d = 1'b1;
                            t_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DOOR: begin
                    // A repeat call at this floor keeps the door open for a fresh interval.
                    pending_d[floor] = 1'b0;
                    if (!call_n[floor]) begin
                        t_load  = 1'b1;
                        t_value = DOOR_LOAD;
                    end else if (t_done) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // The step flag always clears, so a pulse swallowed by an emergency stop is not re-issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            floor   <= '0;
            pending <= '0;
            dir_up  <= 1'b1;
            step    <= 1'b0;
        end else begin
            state   <= state_d;
            floor   <= floor_d;
            pending <= pending_d;
            dir_up  <= dir_up_d;
            step    <= step_d;
        end
    end

    assign up_n      = !(run && state == UP   && step);
    assign down_n    = !(run && state == DOWN && step);
    assign hold      = !(run && (state == UP || state == DOWN));
    assign door_open = run && state == DOOR;
    assign top_alarm = (floor == TOP);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler; define EMERGENCY_STOP_EN to include the stop scenario.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] call_n = 8'hFF;
`ifdef EMERGENCY_STOP_EN
    logic       estop_n = 1'b1;
`endif
    logic       up_n, down_n, hold, door_open, dir_up, top_alarm;
    logic [2:0] floor;
    logic [7:0] pending;

    int tests_run = 0;
    int tests_failed = 0;

    int up_cnt, down_cnt, door_cnt, last_door, floor_t, viol;
    int up_t[8];
    int down_t[8];
    logic [2:0] tgt;

    always #5 clk = ~clk;

    elevator_call_scheduler dut (
        .clk       (clk),
        .reset     (reset),
`ifdef EMERGENCY_STOP_EN
        .estop_n   (estop_n),
`endif
        .call_n    (call_n),
        .up_n      (up_n),
        .down_n    (down_n),
        .hold      (hold),
        .floor     (floor),
        .pending   (pending),
        .door_open (door_open),
        .dir_up    (dir_up),
        .top_alarm (top_alarm)
    );

    task automatic clear_stats(input logic [2:0] target);
        up_cnt = 0; down_cnt = 0; door_cnt = 0; last_door = -1; floor_t = -1; viol = 0;
        tgt = target;
        for (int i = 0; i < 8; i++) begin up_t[i] = -1; down_t[i] = -1; end
    endtask

    // Sample 1 time unit after the driving negedge, far from the rising edge.
    task automatic observe(input int k);
        #1;
        if (!up_n) begin if (up_cnt < 8) up_t[up_cnt] = k; up_cnt++; end
        if (!down_n) begin if (down_cnt < 8) down_t[down_cnt] = k; down_cnt++; end
        if (door_open) begin door_cnt++; last_door = k; end
        if (floor == tgt && floor_t < 0) floor_t = k;
        if ((!up_n && !down_n) || ((!up_n || !down_n) && hold)) viol++;
    endtask

    task automatic do_reset();
        call_n = 8'hFF;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        clear_stats(3'd0);
        for (int k = 1; k <= 50; k++) begin @(negedge clk); observe(k); end
        tests_run++; if (up_cnt + down_cnt !== 0) begin tests_failed++; $display("FAIL reset_pulses: got %0d expected 0", up_cnt + down_cnt); end
        tests_run++; if (floor !== 3'd0) begin tests_failed++; $display("FAIL reset_floor: got %0d expected 0", floor); end
        tests_run++; if ({hold, up_n, down_n, door_open, dir_up} !== 5'b11101) begin tests_failed++; $display("FAIL reset_ctrl: got %b expected 11101", {hold, up_n, down_n, door_open, dir_up}); end
        tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL reset_pending: got %h expected 00", pending); end
        tests_run++; if (top_alarm !== 1'b0) begin tests_failed++; $display("FAIL reset_top_alarm: got %b expected 0", top_alarm); end
    endtask

    // Floor 0 -> 3: pulses at 2,10,18; floor 3 at 26; door 26..41.
    task automatic test_single_call();
        clear_stats(3'd3);
        @(negedge clk); call_n = 8'hF7;
        for (int k = 1; k <= 50; k++) begin @(negedge clk); call_n = 8'hFF; observe(k); end
        tests_run++; if (up_cnt !== 3) begin tests_failed++; $display("FAIL t2_up_count: got %0d expected 3", up_cnt); end
        tests_run++; if (up_t[0] !== 2 || up_t[1] !== 10 || up_t[2] !== 18) begin tests_failed++; $display("FAIL t2_pulse_times: got %0d %0d %0d expected 2 10 18", up_t[0], up_t[1], up_t[2]); end
        tests_run++; if (floor_t !== 26) begin tests_failed++; $display("FAIL t2_floor_time: got %0d expected 26", floor_t); end
        tests_run++; if (door_cnt !== 16 || last_door !== 41) begin tests_failed++; $display("FAIL t2_door: got %0d cycles ending %0d expected 16 ending 41", door_cnt, last_door); end
        tests_run++; if (pending !== 8'h00 || hold !== 1'b1 || door_open !== 1'b0) begin tests_failed++; $display("FAIL t2_end_idle: got pending=%h hold=%b door=%b expected 00 1 0", pending, hold, door_open); end
        tests_run++; if (down_cnt !== 0 || viol !== 0) begin tests_failed++; $display("FAIL t2_protocol: got down=%0d viol=%0d expected 0 0", down_cnt, viol); end
    endtask

    // Floor 3 -> 6 with call 1 arriving at floor 4; reverse and serve 1.
    task automatic test_reversal();
        clear_stats(3'd1);
        @(negedge clk); call_n = 8'hBF;
        for (int k = 1; k <= 105; k++) begin
            @(negedge clk);
            call_n = (k == 10) ? 8'hFD : 8'hFF;
            observe(k);
            if (k == 10) begin
                tests_run++; if (floor !== 3'd4) begin tests_failed++; $display("FAIL t3_floor_at_call: got %0d expected 4", floor); end
            end
            if (k == 40) begin
                tests_run++; if (floor !== 3'd6 || door_open !== 1'b1) begin tests_failed++; $display("FAIL t3_serve_6_first: got floor=%0d door=%b expected 6 1", floor, door_open); end
            end
        end
        tests_run++; if (up_cnt !== 3 || down_cnt !== 5) begin tests_failed++; $display("FAIL t3_step_counts: got up=%0d down=%0d expected 3 5", up_cnt, down_cnt); end
        tests_run++; if (down_t[0] !== 43 || down_t[4] !== 75) begin tests_failed++; $display("FAIL t3_down_times: got %0d %0d expected 43 75", down_t[0], down_t[4]); end
        tests_run++; if (floor_t !== 83 || floor !== 3'd1) begin tests_failed++; $display("FAIL t3_reach_1: got t=%0d floor=%0d expected 83 1", floor_t, floor); end
        tests_run++; if (dir_up !== 1'b0 || pending !== 8'h00) begin tests_failed++; $display("FAIL t3_end: got dir_up=%b pending=%h expected 0 00", dir_up, pending); end
        tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL t3_protocol: got %0d expected 0", viol); end
    endtask

    // Floor 1 -> 7: six up steps, top_alarm at the top, nothing beyond.
    task automatic test_top();
        clear_stats(3'd7);
        @(negedge clk); call_n = 8'h7F;
        for (int k = 1; k <= 90; k++) begin @(negedge clk); call_n = 8'hFF; observe(k); end
        tests_run++; if (up_cnt !== 6 || up_t[5] !== 42) begin tests_failed++; $display("FAIL t4_up_steps: got %0d last %0d expected 6 last 42", up_cnt, up_t[5]); end
        tests_run++; if (floor_t !== 50) begin tests_failed++; $display("FAIL t4_top_time: got %0d expected 50", floor_t); end
        tests_run++; if (top_alarm !== 1'b1 || floor !== 3'd7) begin tests_failed++; $display("FAIL t4_top_alarm: got alarm=%b floor=%0d expected 1 7", top_alarm, floor); end
        tests_run++; if (door_cnt !== 16 || dir_up !== 1'b1) begin tests_failed++; $display("FAIL t4_door_dir: got door=%0d dir_up=%b expected 16 1", door_cnt, dir_up); end
    endtask

    // Call at the current floor opens the door; a repeat at k=10 restarts the 16-cycle count.
    task automatic test_door_repeat();
        do_reset();
        clear_stats(3'd0);
        @(negedge clk); call_n = 8'hFE;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            call_n = (k == 10) ? 8'hFE : 8'hFF;
            observe(k);
            if (k == 11) begin
                tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL t4b_repeat_cleared: got %h expected 00", pending); end
            end
        end
        tests_run++; if (door_cnt !== 25 || last_door !== 26) begin tests_failed++; $display("FAIL t4b_door_restart: got %0d ending %0d expected 25 ending 26", door_cnt, last_door); end
        tests_run++; if (up_cnt + down_cnt !== 0 || floor !== 3'd0) begin tests_failed++; $display("FAIL t4b_no_move: got pulses=%0d floor=%0d expected 0 0", up_cnt + down_cnt, floor); end
    endtask

    // Reset asserted while the timer holds 4 in the second up step.
    task automatic test_reset_mid_move();
        do_reset();
        clear_stats(3'd7);
        @(negedge clk); call_n = 8'hF7;
        for (int k = 1; k <= 13; k++) begin @(negedge clk); call_n = 8'hFF; observe(k); end
        tests_run++; if (floor !== 3'd1 || hold !== 1'b0) begin tests_failed++; $display("FAIL t5_mid_move: got floor=%0d hold=%b expected 1 0", floor, hold); end
        reset = 1'b1;
        #1;
        tests_run++; if ({floor, pending, hold, up_n, down_n, door_open, dir_up} !== {3'd0, 8'h00, 5'b11101}) begin tests_failed++; $display("FAIL t5_async_reset: got floor=%0d pending=%h ctrl=%b expected 0 00 11101", floor, pending, {hold, up_n, down_n, door_open, dir_up}); end
        @(negedge clk); reset = 1'b0;
        clear_stats(3'd7);
        for (int k = 1; k <= 20; k++) begin @(negedge clk); observe(k); end
        tests_run++; if (up_cnt + down_cnt !== 0 || pending !== 8'h00 || floor !== 3'd0) begin tests_failed++; $display("FAIL t5_calls_discarded: got pulses=%0d pending=%h floor=%0d expected 0 00 0", up_cnt + down_cnt, pending, floor); end
    endtask

`ifdef EMERGENCY_STOP_EN
    // Stop k=4..23 during the first up step (timer 5); call 5 latched during the stop.
    task automatic test_estop();
        int stop_bad;
        stop_bad = 0;
        do_reset();
        clear_stats(3'd1);
        @(negedge clk); call_n = 8'hF7;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            call_n = (k == 8) ? 8'hDF : 8'hFF;
            if (k == 4) estop_n = 1'b0;
            if (k == 24) estop_n = 1'b1;
            observe(k);
            if (k >= 4 && k <= 23 && (hold !== 1'b1 || up_n !== 1'b1 || floor !== 3'd0 || door_open !== 1'b0)) stop_bad++;
            if (k == 10) begin
                tests_run++; if (pending !== 8'h28) begin tests_failed++; $display("FAIL t6_latch_in_stop: got %h expected 28", pending); end
            end
        end
        tests_run++; if (stop_bad !== 0) begin tests_failed++; $display("FAIL t6_frozen: got %0d bad cycles expected 0", stop_bad); end
        tests_run++; if (floor_t !== 30 || up_t[1] !== 30) begin tests_failed++; $display("FAIL t6_resume: got floor_t=%0d pulse=%0d expected 30 30", floor_t, up_t[1]); end
        tests_run++; if (up_cnt !== 5 || floor !== 3'd5 || pending !== 8'h00) begin tests_failed++; $display("FAIL t6_served: got up=%0d floor=%0d pending=%h expected 5 5 00", up_cnt, floor, pending); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_call();
        test_reversal();
        test_top();
        test_door_repeat();
        test_reset_mid_move();
`ifdef EMERGENCY_STOP_EN
        test_estop();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
